clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider producing a 50%-duty divided clock for both odd and even ratios. It uses a posedge counter, a posedge phase flop and a negedge phase flop; for odd ratios the two phases are ANDed. It sits directly downstream of configuration logic, which loads ratios through a valid/ready handshake. It replaces fixed-ratio dividers wherever software or a controller must change the ratio without glitching the output.

Parameters:
CNT_W, 8, width of ratio and counter; legal ratios are 2..2^CNT_W-1.
DEFAULT_DIV, 3, active ratio after reset; must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.

Ports:
clk  input  1  source clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run request; sampled only at period boundaries and in PARK.
cfg_valid  input  1  new ratio offered.
cfg_div  input  CNT_W  requested ratio N.
cfg_ready  output  1  divider can accept a new ratio.
cfg_err  output  1  one-cycle pulse; the last accepted cfg_div was illegal (<2).
clk_out  output  1  divided clock.
tick  output  1  one-clk pulse (posedge domain) in the first cycle of each output period.

Behaviour:
- Reset is asynchronous and active-low (rst_n), clock clk. Reset values:
  - state=PARK, cnt_p=0, clk_p=0, clk_n=0, clk_out=0.
  - tick=0, cfg_ready=1, cfg_err=0, pending=empty, N_act=DEFAULT_DIV, odd_act=DEFAULT_DIV[0].
- Phase high length H = N_act/2 when N_act is even; H = (N_act+1)/2 when N_act is odd.
- clk_p is a posedge flop: 1 while cnt_p < H, else 0.
- clk_n is a negedge flop that samples clk_p (clk_p delayed by half a cycle); its reset is asynchronous low.
- clk_out = odd_act ? (clk_p & clk_n) : clk_p.
  - Odd N: high for N/2 clk periods (e.g. N=3 gives 1.5 high, 1.5 low).
  - Even N: high N/2, low N/2.
- FSM states: PARK, RUN.
  - PARK: cnt_p=0, clk_p=0. If pending is set, apply it at the next posedge. On a posedge with en=1, go to RUN with cnt_p<=0, clk_p<=1, tick<=1.
  - RUN: cnt_p increments each posedge. At the posedge where cnt_p==N_act-1 (the boundary):
    - en=0: go to PARK, clk_p<=0. clk_out stays low; a period is never truncated.
    - en=1: cnt_p<=0, clk_p<=1, tick<=1. If pending is set, load N_act/odd_act from it at this same edge and clear pending; the new period uses the new ratio.
- Handshake:
  - A transfer occurs when cfg_valid & cfg_ready at a posedge.
  - If cfg_div >= 2: capture into pending; cfg_ready<=0 until the cycle after pending is applied.
  - If cfg_div < 2: cfg_err<=1 for exactly one cycle, pending is unchanged, cfg_ready stays 1.
  - A transfer at the same edge as a RUN boundary is not applied at that boundary; it is applied at the next one.
- Glitch-free:
  - The ratio and the odd/even select change only at a boundary, where clk_p rises and clk_n=0.
  - No clk_out pulse or gap shorter than min(old, new) half-period.
- tick: registered; exactly one pulse per output period while in RUN; 0 in PARK.
- Counter wrap: cnt_p never exceeds N_act-1.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously); pending is discarded.

Test Plan:
- Reset, en=1, DEFAULT_DIV=3 -> clk_out period 3 clk, high 1.5 clk (rises on a clk negedge, falls on a clk posedge); tick every 3rd cycle.
- Load cfg_div=4 mid-period -> cfg_ready drops; the current N=3 period completes; next periods are 2 high/2 low; no runt; cfg_ready returns 1 the cycle after the boundary.
- Alternate cfg_div 5 then 2 across boundaries -> periods 5 (2.5/2.5) then 2 (1/1); clk_out has no glitch at either switch.
- cfg_div=0 and cfg_div=1 -> cfg_err one-cycle pulse each time; ratio unchanged; cfg_ready stays 1.
- Deassert en mid-period at N=5 -> period finishes, clk_out stays 0, tick stops; reassert -> clk_out rises one posedge later with tick=1.
- Assert rst_n low mid-high-phase -> clk_out, tick, cfg_err go 0 immediately, cfg_ready 1; after release with en=1, output restarts with period DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer divider with a 50% duty output for odd and even ratios.
// New ratio takes effect at the next period boundary; cfg_ready stays low while a ratio is pending.
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic {PARK, RUN} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] cnt_p;
  logic [CNT_W-1:0] n_act;
  logic             odd_act;
  logic [CNT_W-1:0] pend_div;
  logic             pend_vld;
  logic             clk_p;
  logic             clk_n;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_last;
  logic             xfer;
  logic             apply_pend;

  // High phase of clk_p: N/2 for even, (N+1)/2 for odd.
  assign half       = (n_act >> 1) + {{(CNT_W-1){1'b0}}, n_act[0]};
  assign cnt_inc    = cnt_p + ONE;
  assign at_last    = (cnt_p == (n_act - ONE));
  assign xfer       = cfg_valid & cfg_ready;
  assign apply_pend = pend_vld & ((state == PARK) | (at_last & en));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PARK;
      cnt_p     <= '0;
      clk_p     <= 1'b0;
      tick      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_div  <= '0;
      n_act     <= DEF_DIV;
      odd_act   <= DEF_DIV[0];
    end else begin
      tick    <= 1'b0;
      cfg_err <= 1'b0;

      if (apply_pend) begin
        n_act     <= pend_div;
        odd_act   <= pend_div[0];
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end

      case (state)
        PARK: begin
          cnt_p <= '0;
          clk_p <= 1'b0;
          if (en) begin
            state <= RUN;
            clk_p <= 1'b1;
            tick  <= 1'b1;
          end
        end
        RUN: begin
          if (at_last) begin
            cnt_p <= '0;
            if (en) begin
              clk_p <= 1'b1;
              tick  <= 1'b1;
            end else begin
              state <= PARK;
              clk_p <= 1'b0;
            end
          end else begin
            cnt_p <= cnt_inc;
            clk_p <= (cnt_inc < half);
          end
        end
        default: begin
          state <= PARK;
          cnt_p <= '0;
          clk_p <= 1'b0;
        end
      endcase

      // Pending is empty whenever cfg_ready is high, so this never collides with apply_pend.
      if (xfer) begin
        if (cfg_div >= TWO) begin
          pend_vld  <= 1'b1;
          pend_div  <= cfg_div;
          cfg_ready <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end

  // Select only changes at a boundary, where clk_p rises and clk_n is low, so the mux cannot glitch.
  assign clk_out = odd_act ? (clk_p & clk_n) : clk_p;

  a_cnt_wrap: assert property (@(posedge clk) disable iff (!rst_n) cnt_p < n_act);
  a_ratio_legal: assert property (@(posedge clk) disable iff (!rst_n) n_act >= TWO);
  a_ready_vs_pend: assert property (@(posedge clk) disable iff (!rst_n) !(pend_vld && cfg_ready));
  a_park_quiet: assert property (@(posedge clk) disable iff (!rst_n) (state == PARK) |-> !tick);

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: half-cycle waveform checks against a period-level reference model.
module tb_clk_div_prog;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: which period we are in, how far into it, and the handshake state.
  bit m_run, m_pend, m_ready, m_err, m_tick;
  int m_j, m_n, m_pdiv;

  always @(posedge clk or negedge rst_n) begin : model
    bit take;
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_ready = 1; m_err = 0; m_tick = 0;
      m_j = 0; m_n = DEFAULT_DIV; m_pdiv = 0;
    end else begin
      take   = cfg_valid && m_ready;
      m_tick = 0;
      m_err  = 0;
      if (!m_run) begin
        if (m_pend) begin m_n = m_pdiv; m_pend = 0; m_ready = 1; end
        if (en) begin m_run = 1; m_j = 0; m_tick = 1; end
      end else if (m_j == m_n - 1) begin
        if (en) begin
          if (m_pend) begin m_n = m_pdiv; m_pend = 0; m_ready = 1; end
          m_j = 0; m_tick = 1;
        end else begin
          m_run = 0;
        end
      end else begin
        m_j++;
      end
      if (take) begin
        if (int'(cfg_div) >= 2) begin m_pend = 1; m_pdiv = int'(cfg_div); m_ready = 0; end
        else m_err = 1;
      end
    end
  end

  // Half-cycle index hj inside a period of N cycles: even N is high for hj < N,
  // odd N is high for 1 <= hj <= N (rises on a negedge, falls on a posedge).
  function automatic bit exp_clk(input int h);
    int hj;
    hj = 2 * m_j + h;
    if (!m_run) return 1'b0;
    if (m_n % 2 == 1) return (hj >= 1) && (hj <= m_n);
    return hj < m_n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    #13;
    checks++;
    if ({clk_out, tick, cfg_ready, cfg_err} !== 4'b0010)
      begin errors++; $display("FAIL reset_state out/tick/rdy/err got %b%b%b%b exp 0010", clk_out, tick, cfg_ready, cfg_err); end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({clk_out, tick, cfg_ready, cfg_err} !== 4'b0010)
      begin errors++; $display("FAIL park_idle out/tick/rdy/err got %b%b%b%b exp 0010", clk_out, tick, cfg_ready, cfg_err); end
  endtask

  task automatic test_default_run();
    int ticks = 0;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({clk_out, tick, cfg_ready, cfg_err} !== {exp_clk(0), m_tick, m_ready, m_err})
        begin errors++; $display("FAIL default_pos t=%0t got %b%b%b%b exp %b%b%b%b", $time, clk_out, tick, cfg_ready, cfg_err, exp_clk(0), m_tick, m_ready, m_err); end
      if (tick === 1'b1) ticks++;
      @(negedge clk); #1;
      checks++;
      if (clk_out !== exp_clk(1))
        begin errors++; $display("FAIL default_neg t=%0t clk_out got %b exp %b", $time, clk_out, exp_clk(1)); end
    end
    checks++;
    if (ticks !== 4) begin errors++; $display("FAIL default_ticks got %0d exp 4", ticks); end
  endtask

  // Offers the listed ratios one after another, each as soon as the divider is ready.
  task automatic test_ratio_seq(input string name, input int d0, input int d1, input int cnt, input int cycles);
    int divs[2];
    int k = 0;
    divs[0] = d0; divs[1] = d1;
    en = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({clk_out, tick, cfg_ready, cfg_err} !== {exp_clk(0), m_tick, m_ready, m_err})
        begin errors++; $display("FAIL %s_pos t=%0t got %b%b%b%b exp %b%b%b%b", name, $time, clk_out, tick, cfg_ready, cfg_err, exp_clk(0), m_tick, m_ready, m_err); end
      if (cfg_valid) begin
        cfg_valid = 1'b0; k++;
      end else if (m_ready && k < cnt) begin
        cfg_valid = 1'b1; cfg_div = 8'(divs[k]);
      end
      @(negedge clk); #1;
      checks++;
      if (clk_out !== exp_clk(1))
        begin errors++; $display("FAIL %s_neg t=%0t clk_out got %b exp %b", name, $time, clk_out, exp_clk(1)); end
    end
    checks++;
    if (k !== cnt) begin errors++; $display("FAIL %s_accepted got %0d exp %0d", name, k, cnt); end
  endtask

  task automatic test_en_toggle();
    bit sent = 0;
    en = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({clk_out, tick, cfg_ready, cfg_err} !== {exp_clk(0), m_tick, m_ready, m_err})
        begin errors++; $display("FAIL en_toggle_pos t=%0t got %b%b%b%b exp %b%b%b%b", $time, clk_out, tick, cfg_ready, cfg_err, exp_clk(0), m_tick, m_ready, m_err); end
      if (cfg_valid) cfg_valid = 1'b0;
      else if (!sent && m_ready) begin cfg_valid = 1'b1; cfg_div = 8'd5; sent = 1; end
      if (i == 18) en = 1'b0;
      if (i == 32) en = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (clk_out !== exp_clk(1))
        begin errors++; $display("FAIL en_toggle_neg t=%0t clk_out got %b exp %b", $time, clk_out, exp_clk(1)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({clk_out, tick, cfg_ready, cfg_err} !== {exp_clk(0), m_tick, m_ready, m_err})
        begin errors++; $display("FAIL random_pos t=%0t got %b%b%b%b exp %b%b%b%b", $time, clk_out, tick, cfg_ready, cfg_err, exp_clk(0), m_tick, m_ready, m_err); end
      en        = ($urandom_range(0, 7) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = 8'($urandom_range(0, 7));
      @(negedge clk); #1;
      checks++;
      if (clk_out !== exp_clk(1))
        begin errors++; $display("FAIL random_neg t=%0t clk_out got %b exp %b", $time, clk_out, exp_clk(1)); end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit armed = 0;
    bit hit = 0;
    int ticks = 0;
    en = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({clk_out, tick, cfg_ready, cfg_err} !== {exp_clk(0), m_tick, m_ready, m_err})
        begin errors++; $display("FAIL rstmid_pos t=%0t got %b%b%b%b exp %b%b%b%b", $time, clk_out, tick, cfg_ready, cfg_err, exp_clk(0), m_tick, m_ready, m_err); end
      if (cfg_valid) cfg_valid = 1'b0;
      else if (!armed && m_tick && m_ready) begin cfg_valid = 1'b1; cfg_div = 8'd6; armed = 1; end
      @(negedge clk); #1;
      checks++;
      if (clk_out !== exp_clk(1))
        begin errors++; $display("FAIL rstmid_neg t=%0t clk_out got %b exp %b", $time, clk_out, exp_clk(1)); end
      if (m_pend && clk_out === 1'b1) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_setup no high phase with pending ratio got 0 exp 1"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, cfg_ready, cfg_err} !== 4'b0010)
      begin errors++; $display("FAIL rstmid_async out/tick/rdy/err got %b%b%b%b exp 0010", clk_out, tick, cfg_ready, cfg_err); end
    @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({clk_out, tick, cfg_ready, cfg_err} !== {exp_clk(0), m_tick, m_ready, m_err})
        begin errors++; $display("FAIL restart_pos t=%0t got %b%b%b%b exp %b%b%b%b", $time, clk_out, tick, cfg_ready, cfg_err, exp_clk(0), m_tick, m_ready, m_err); end
      if (tick === 1'b1) ticks++;
      @(negedge clk); #1;
      checks++;
      if (clk_out !== exp_clk(1))
        begin errors++; $display("FAIL restart_neg t=%0t clk_out got %b exp %b", $time, clk_out, exp_clk(1)); end
    end
    checks++;
    if (ticks !== 4) begin errors++; $display("FAIL restart_ticks got %0d exp 4", ticks); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_run();
    test_ratio_seq("load_even", 4, 0, 1, 16);
    test_random();
    test_ratio_seq("alternate", 5, 2, 2, 40);
    test_ratio_seq("illegal", 0, 1, 2, 12);
    test_en_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
